// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: turns the core's single-cycle SRAM port into one sram-like
// req/addr_ok/data_ok transaction per M-stage access, stalling the core meanwhile.
module d_sram_to_sram_like #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // CPU side
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [DATA_W-1:0] data_sram_wdata,
    output logic [DATA_W-1:0] data_sram_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    // sram-like bus side
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                data_ok_seen;

    assign data_wr         = |data_sram_wen;
    assign data_wdata      = data_sram_wdata;
    assign data_sram_rdata = rdata_q;
    // DONE drops the stall so the pipeline can advance while the result is held.
    assign d_stall         = data_sram_en & (state_q != DONE);

    // Reads always fetch the whole word; the core extracts bytes/halves itself.
    assign data_addr = data_wr ? data_sram_addr : {data_sram_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        data_size = 2'd2;
        if (data_wr) begin
            case (data_sram_wen)
                4'b0011, 4'b1100:                   data_size = 2'd1;
                4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
                default:                            data_size = 2'd2;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d      = state_q;
        rdata_d      = rdata_q;
        data_req     = 1'b0;
        data_ok_seen = 1'b0;
        case (state_q)
            IDLE: begin
                data_req = data_sram_en;
                if (data_sram_en && data_addr_ok) begin
                    data_ok_seen = data_data_ok;
                    state_d      = data_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                // Completes even if en has dropped; the bus cannot cancel a transaction.
                if (data_data_ok) begin
                    data_ok_seen = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (!longest_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (data_ok_seen && !data_wr) rdata_d = data_rdata;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed bench for d_sram_to_sram_like; returned read data is tracked
// through a scoreboard queue filled when data_ok is driven.
module tb_d_sram_to_sram_like;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              d_stall;
    logic              longest_stall;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_addr_ok;
    logic              data_data_ok;

    int unsigned n_compared = 0;
    int unsigned n_mismatch = 0;
    int unsigned hs_count   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rdata;

    d_sram_to_sram_like #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .d_stall         (d_stall),
        .longest_stall   (longest_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_rdata      (data_rdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok)
    );

    always #5 clk = ~clk;

    // Counts accepted address handshakes, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && data_req && data_addr_ok) hs_count <= hs_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, data_sram_rdata);
        end else begin
            exp = exp_q.pop_front();
            check(tag, data_sram_rdata, exp);
        end
    endtask

    // Drive a bus completion; reads update the model and push the expected rdata.
    task automatic bus_data(input logic [31:0] value, input logic is_read);
        data_data_ok = 1'b1;
        data_rdata   = value;
        if (is_read) model_rdata = value;
        exp_q.push_back(model_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
        longest_stall = 1'b0;
    endtask

    initial begin
        int unsigned hs_base;
        rst             = 1'b1;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        data_rdata      = '0;
        model_rdata     = '0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        mid();
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_stall", {31'b0, d_stall}, 32'd0);
        check("reset_req", {31'b0, data_req}, 32'd0);

        // 1: word load, addr_ok cycle 0, data_ok cycle 2
        step();
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h1000_0004;
        data_addr_ok   = 1'b1;
        mid();
        check("t1_c0_req", {31'b0, data_req}, 32'd1);
        check("t1_c0_size", {30'b0, data_size}, 32'd2);
        check("t1_c0_wr", {31'b0, data_wr}, 32'd0);
        check("t1_c0_addr", data_addr, 32'h1000_0004);
        check("t1_c0_stall", {31'b0, d_stall}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        mid();
        check("t1_c1_req", {31'b0, data_req}, 32'd0);
        check("t1_c1_stall", {31'b0, d_stall}, 32'd1);
        step();
        bus_data(32'hDEAD_BEEF, 1'b1);
        mid();
        check("t1_c2_req", {31'b0, data_req}, 32'd0);
        check("t1_c2_stall", {31'b0, d_stall}, 32'd1);
        step();
        data_data_ok = 1'b0;
        mid();
        check("t1_c3_stall", {31'b0, d_stall}, 32'd0);
        check("t1_c3_req", {31'b0, data_req}, 32'd0);
        check_pop("t1_rdata");
        step();
        idle_inputs();

        // 2: byte store with same-cycle addr_ok/data_ok; read data bus carries junk
        step();
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b0100;
        data_sram_addr  = 32'h1000_0006;
        data_sram_wdata = 32'h00AB_0000;
        data_addr_ok    = 1'b1;
        bus_data(32'h1234_5678, 1'b0);
        mid();
        check("t2_size", {30'b0, data_size}, 32'd0);
        check("t2_wr", {31'b0, data_wr}, 32'd1);
        check("t2_addr", data_addr, 32'h1000_0006);
        check("t2_wdata", data_wdata, 32'h00AB_0000);
        check("t2_stall_c0", {31'b0, d_stall}, 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        mid();
        check("t2_stall_c1", {31'b0, d_stall}, 32'd0);
        check("t2_req_c1", {31'b0, data_req}, 32'd0);
        check_pop("t2_rdata_unchanged");
        step();
        idle_inputs();

        // 3: unaligned byte load, addr_ok withheld 3 cycles, then single-cycle completion
        step();
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h1000_0013;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                data_addr_ok = 1'b1;
                bus_data(32'hCAFE_F00D, 1'b1);
            end
            mid();
            check($sformatf("t3_req_c%0d", i), {31'b0, data_req}, 32'd1);
            check($sformatf("t3_addr_c%0d", i), data_addr, 32'h1000_0010);
            check($sformatf("t3_stall_c%0d", i), {31'b0, d_stall}, 32'd1);
            if (i < 3) step();
        end
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        mid();
        check("t3_stall_done", {31'b0, d_stall}, 32'd0);
        check_pop("t3_rdata");
        step();
        idle_inputs();

        // 4: load completes while longest_stall is held for 4 more cycles
        step();
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h1000_0020;
        data_addr_ok   = 1'b1;
        longest_stall  = 1'b1;
        bus_data(32'h0BAD_C0DE, 1'b1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h7777_7777;
        mid();
        check_pop("t4_rdata");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) mid();
            check($sformatf("t4_hold_stall_%0d", i), {31'b0, d_stall}, 32'd0);
            check($sformatf("t4_hold_req_%0d", i), {31'b0, data_req}, 32'd0);
            check($sformatf("t4_hold_rdata_%0d", i), data_sram_rdata, model_rdata);
            step();
        end
        longest_stall = 1'b0;
        mid();
        check("t4_release_stall", {31'b0, d_stall}, 32'd0);
        check("t4_release_req", {31'b0, data_req}, 32'd0);
        step();
        mid();
        check("t4_idle_req", {31'b0, data_req}, 32'd1);
        check("t4_idle_stall", {31'b0, d_stall}, 32'd1);
        step();
        data_sram_en = 1'b0;
        mid();
        check("t4_en_drop_req", {31'b0, data_req}, 32'd0);
        step();
        mid();
        check("t4_en_drop_stall", {31'b0, d_stall}, 32'd0);
        check("t4_en_drop_rdata", data_sram_rdata, model_rdata);

        // 5: half store then word load back to back
        step();
        hs_base         = hs_count;
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'b1100;
        data_sram_addr  = 32'h1000_0002;
        data_sram_wdata = 32'hBEEF_0000;
        data_addr_ok    = 1'b1;
        mid();
        check("t5_st_req", {31'b0, data_req}, 32'd1);
        check("t5_st_size", {30'b0, data_size}, 32'd1);
        check("t5_st_addr", data_addr, 32'h1000_0002);
        step();
        data_addr_ok = 1'b0;
        bus_data(32'h9999_9999, 1'b0);
        mid();
        check("t5_st_wait_req", {31'b0, data_req}, 32'd0);
        step();
        data_data_ok = 1'b0;
        mid();
        check("t5_st_done_stall", {31'b0, d_stall}, 32'd0);
        check_pop("t5_st_rdata");
        step();
        data_sram_wen  = 4'b0000;
        data_sram_addr = 32'h2000_0008;
        data_addr_ok   = 1'b1;
        bus_data(32'h5555_AAAA, 1'b1);
        mid();
        check("t5_ld_req", {31'b0, data_req}, 32'd1);
        check("t5_ld_size", {30'b0, data_size}, 32'd2);
        check("t5_ld_wr", {31'b0, data_wr}, 32'd0);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        mid();
        check("t5_ld_stall", {31'b0, d_stall}, 32'd0);
        check("t5_ld_req_after", {31'b0, data_req}, 32'd0);
        check_pop("t5_ld_rdata");
        step();
        idle_inputs();
        step();
        check("t5_handshakes", hs_count - hs_base, 32'd2);

        // 6: asynchronous reset while in WAIT; stale data_ok afterwards is ignored
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h1000_0040;
        data_addr_ok   = 1'b1;
        step();
        data_addr_ok = 1'b0;
        mid();
        check("t6_wait_req", {31'b0, data_req}, 32'd0);
        check("t6_wait_rdata", data_sram_rdata, model_rdata);
        #1;
        rst = 1'b1;
        #1;
        model_rdata = 32'h0;
        check("t6_async_rdata", data_sram_rdata, model_rdata);
        check("t6_async_req", {31'b0, data_req}, 32'd1);
        check("t6_async_stall", {31'b0, d_stall}, 32'd1);
        data_sram_en = 1'b0;
        step();
        rst          = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        step();
        data_data_ok = 1'b0;
        mid();
        check("t6_stale_rdata", data_sram_rdata, model_rdata);
        check("t6_stale_stall", {31'b0, d_stall}, 32'd0);
        step();
        data_sram_en = 1'b1;
        mid();
        check("t6_post_req", {31'b0, data_req}, 32'd1);
        check("t6_post_stall", {31'b0, d_stall}, 32'd1);
        step();
        idle_inputs();
        check("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
